hwpe_ctrl_offload_seq: RTL and testbench
========================================

Name: hwpe_ctrl_offload_seq

Overview:
- Hardware offload sequencer: a peripheral-bus master that programs an HWPE control slave on behalf of a producer (DMA/scheduler) with no core involvement.
- Per job: acquires a context, writes N_JOB_REGS job registers, then writes TRIGGER.
- Tracks jobs in flight against the slave's context depth using the slave's done event.

Parameters:
- N_JOB_REGS, 4, job registers written per job (1..16).
- N_CONTEXT, 2, maximum jobs outstanding in the slave.
- TRIGGER_OFFS, 32'h00, byte offset of the TRIGGER register.
- ACQUIRE_OFFS, 32'h04, byte offset of the ACQUIRE register.
- JOB_OFFS, 32'h20, byte offset of the first job register; register k is at JOB_OFFS+4k.
- RETRY_WAIT, 8, backoff cycles after a failed acquire (>=1).
- ID_WIDTH, 16, width of the bus transaction ID.
- MASTER_ID, 1, constant ID driven on id_o.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- base_addr_i  in  32  slave base address; sampled at job accept.
- job_valid_i  in  1  job descriptor valid.
- job_ready_o  out  1  sequencer accepts a descriptor.
- job_data_i  in  32*N_JOB_REGS  descriptor; word k goes to job register k.
- req_o  out  1  bus request.
- gnt_i  in  1  bus grant.
- add_o  out  32  bus byte address.
- wen_o  out  1  1 = read, 0 = write.
- be_o  out  4  byte enables; always 4'hF.
- data_o  out  32  write data.
- id_o  out  ID_WIDTH  transaction ID.
- r_data_i  in  32  read data.
- r_valid_i  in  1  read response valid.
- evt_done_i  in  1  single-cycle done pulse from the slave.
- busy_o  out  1  state != IDLE, or outstanding != 0.
- outstanding_o  out  $clog2(N_CONTEXT+1)  jobs triggered and not yet done.
- jobs_done_o  out  16  completed-job counter.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE; job buffer cleared; req_o=0, add_o=0, wen_o=1, data_o=0, job_ready_o=0; outstanding_o=0, jobs_done_o=0, err_o=0. Reset aborts any operation in progress, including a held request.
- id_o is always MASTER_ID. be_o is always 4'hF.
- Bus rule: once req_o rises, add_o, wen_o and data_o hold stable until the cycle gnt_i=1. A grant completes the transfer in that cycle. At most one read is outstanding. r_valid_i arrives one or more cycles after its grant; r_valid_i outside ACQ_RESP is ignored.
- FSM states: IDLE, ACQ_REQ, ACQ_RESP, BACKOFF, WR_REG, TRIG.
- IDLE: job_ready_o = (outstanding_o < N_CONTEXT).
  - On job_valid_i & job_ready_o: latch job_data_i and base_addr_i, set reg index k=0, go to ACQ_REQ next cycle.
  - job_ready_o is 0 in every other state.
- ACQ_REQ: req_o=1, wen_o=1, add_o=base+ACQUIRE_OFFS. On gnt_i go to ACQ_RESP.
- ACQ_RESP: req_o=0. On r_valid_i:
  - r_data_i[31]=1 (no free context): go to BACKOFF, load counter with RETRY_WAIT.
  - r_data_i[31]=0: go to WR_REG.
- BACKOFF: decrement the counter each cycle; when it reaches 0, go to ACQ_REQ. The retry request is first driven exactly RETRY_WAIT cycles after the response cycle.
- WR_REG: req_o=1, wen_o=0, add_o=base+JOB_OFFS+4k, data_o=word k.
  - On gnt_i: k++.
  - On gnt_i with k==N_JOB_REGS-1: go to TRIG.
  - Back-to-back grants give one write per cycle.
- TRIG: req_o=1, wen_o=0, add_o=base+TRIGGER_OFFS, data_o=0. On gnt_i: outstanding +1, go to IDLE.
- outstanding_o:
  - +1 on trigger grant; -1 on evt_done_i.
  - Trigger grant and evt_done_i in the same cycle: unchanged.
  - evt_done_i with outstanding_o=0 and no trigger grant in that cycle: value unchanged, err_o set.
  - A trigger grant with outstanding_o=N_CONTEXT cannot happen, because job_ready_o gates job acceptance.
- jobs_done_o: +1 on every evt_done_i that decrements outstanding, and on the simultaneous trigger-grant case; wraps 16'hFFFF -> 0.
- err_o: cleared only by rst_i.
- Latency, idle bus (gnt_i=1 whenever requested, read response one cycle after grant), from accept edge to trigger grant: 1 (ACQ_REQ) + 1 (ACQ_RESP) + N_JOB_REGS + 1 = N_JOB_REGS+3 cycles.

Test Plan:
- Basic job, N_JOB_REGS=4, base 0x1000, gnt_i tied 1, acquire returns 0:
  - Bus sequence: read 0x1004, writes 0x1020..0x102C with words 0..3, write 0x1000 data 0.
  - Trigger grant 7 cycles after accept; outstanding_o=1.
- Grant stall: hold gnt_i=0 for 5 cycles during WR_REG k=2 -> add_o=base+0x28 and data_o=word 2 stable throughout; no skipped or duplicated write.
- Busy acquire: first read returns 0xFFFFFFFF, second returns 1 -> second ACQUIRE request driven exactly 8 cycles after the first response (RETRY_WAIT=8), then normal writes.
- Context full, N_CONTEXT=2:
  - Two jobs triggered, no evt_done_i -> job_ready_o=0 while job_valid_i=1.
  - One evt_done_i -> outstanding_o=1, job_ready_o=1 next cycle, jobs_done_o=1.
- Simultaneous events: trigger grant in the same cycle as evt_done_i with outstanding_o=1 -> outstanding_o stays 1, jobs_done_o +1.
- Spurious done and reset: evt_done_i with outstanding_o=0 -> err_o=1. rst_i asserted mid-WR_REG -> req_o=0 and state IDLE next cycle; err_o=0, counters 0.

Source files
------------

// File: rtl/hwpe_ctrl_offload_seq.sv
// hwpe_ctrl_offload_seq: peripheral-bus master that offloads jobs to an HWPE
// control slave. For each accepted descriptor it acquires a context, writes
// the job registers, writes TRIGGER, and then tracks the job until the slave
// signals completion through its done event.
module hwpe_ctrl_offload_seq #(
    parameter int          N_JOB_REGS   = 4,
    parameter int          N_CONTEXT    = 2,
    parameter logic [31:0] TRIGGER_OFFS = 32'h00,
    parameter logic [31:0] ACQUIRE_OFFS = 32'h04,
    parameter logic [31:0] JOB_OFFS     = 32'h20,
    parameter int          RETRY_WAIT   = 8,
    parameter int          ID_WIDTH     = 16,
    parameter int          MASTER_ID    = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [31:0]                       base_addr_i,
    input  logic                              job_valid_i,
    output logic                              job_ready_o,
    input  logic [32*N_JOB_REGS-1:0]          job_data_i,
    output logic                              req_o,
    input  logic                              gnt_i,
    output logic [31:0]                       add_o,
    output logic                              wen_o,
    output logic [3:0]                        be_o,
    output logic [31:0]                       data_o,
    output logic [ID_WIDTH-1:0]               id_o,
    input  logic [31:0]                       r_data_i,
    input  logic                              r_valid_i,
    input  logic                              evt_done_i,
    output logic                              busy_o,
    output logic [$clog2(N_CONTEXT+1)-1:0]    outstanding_o,
    output logic [15:0]                       jobs_done_o,
    output logic                              err_o
);

    localparam int OUT_W = $clog2(N_CONTEXT + 1);
    // Register index wide enough for up to 16 job registers.
    localparam int K_W   = 5;
    localparam int CNT_W = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQ_REQ,
        S_ACQ_RESP,
        S_BACKOFF,
        S_WR_REG,
        S_TRIG
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [31:0]               r_base;
    logic [32*N_JOB_REGS-1:0]  r_job;
    logic [K_W-1:0]            r_k;
    logic [CNT_W-1:0]          r_cnt;
    logic [OUT_W-1:0]          r_outstanding;
    logic [15:0]               r_jobs_done;
    logic                      r_err;

    logic                      w_room;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_acq_busy;
    logic                      w_wr_gnt;
    logic                      w_trig_gnt;
    logic                      w_last;
    logic [31:0]               w_word;
    logic [31:0]               w_job_addr;
    logic                      w_unused_rdata;

    // Only the busy flag of the acquire response carries meaning.
    assign w_unused_rdata = ^r_data_i[30:0];

    assign be_o          = 4'hF;
    assign id_o          = ID_WIDTH'(MASTER_ID);
    assign outstanding_o = r_outstanding;
    assign jobs_done_o   = r_jobs_done;
    assign err_o         = r_err;
    assign busy_o        = (r_state != S_IDLE) || (r_outstanding != '0);

    // A new job may only start while the slave still has a free context slot.
    assign w_room  = (r_outstanding < OUT_W'(N_CONTEXT));
    assign w_ready = (r_state == S_IDLE) && w_room && !rst_i;
    assign job_ready_o = w_ready;

    assign w_last     = (r_k == K_W'(N_JOB_REGS - 1));
    assign w_job_addr = r_base + JOB_OFFS + {{(32-K_W-2){1'b0}}, r_k, 2'b00};

    // Select descriptor word k for the current job-register write.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < N_JOB_REGS; i++) begin
            if (r_k == K_W'(i)) begin
                w_word = r_job[i*32 +: 32];
            end
        end
    end

    // Next-state and bus outputs; address/data are functions of registered
    // state only, so they stay stable while a request waits for its grant.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_acq_busy  = 1'b0;
        w_wr_gnt    = 1'b0;
        w_trig_gnt  = 1'b0;
        req_o       = 1'b0;
        wen_o       = 1'b1;
        add_o       = '0;
        data_o      = '0;
        case (r_state)
            S_IDLE: begin
                if (job_valid_i && w_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ACQ_REQ;
                end
            end
            S_ACQ_REQ: begin
                req_o = 1'b1;
                wen_o = 1'b1;
                add_o = r_base + ACQUIRE_OFFS;
                if (gnt_i) begin
                    w_state_nxt = S_ACQ_RESP;
                end
            end
            S_ACQ_RESP: begin
                if (r_valid_i) begin
                    if (r_data_i[31]) begin
                        // The response cycle counts as the first wait cycle,
                        // so a one-cycle wait retries straight away.
                        w_acq_busy  = 1'b1;
                        w_state_nxt = (RETRY_WAIT > 1) ? S_BACKOFF : S_ACQ_REQ;
                    end else begin
                        w_state_nxt = S_WR_REG;
                    end
                end
            end
            S_BACKOFF: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_ACQ_REQ;
                end
            end
            S_WR_REG: begin
                req_o  = 1'b1;
                wen_o  = 1'b0;
                add_o  = w_job_addr;
                data_o = w_word;
                if (gnt_i) begin
                    w_wr_gnt = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_TRIG;
                    end
                end
            end
            S_TRIG: begin
                req_o  = 1'b1;
                wen_o  = 1'b0;
                add_o  = r_base + TRIGGER_OFFS;
                data_o = '0;
                if (gnt_i) begin
                    w_trig_gnt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job buffer, register index and retry backoff counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_base <= '0;
            r_job  <= '0;
            r_k    <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_base <= base_addr_i;
                r_job  <= job_data_i;
                r_k    <= '0;
            end else if (w_wr_gnt) begin
                r_k <= r_k + K_W'(1);
            end
            if (w_acq_busy) begin
                r_cnt <= CNT_W'(RETRY_WAIT - 1);
            end else if (r_state == S_BACKOFF) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // In-flight job tracking, completion counter and sticky spurious-done flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
            r_jobs_done   <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_trig_gnt && evt_done_i) begin
                // One job leaves as another enters: count unchanged.
                r_jobs_done <= r_jobs_done + 16'd1;
            end else if (w_trig_gnt) begin
                r_outstanding <= r_outstanding + OUT_W'(1);
            end else if (evt_done_i) begin
                if (r_outstanding != '0) begin
                    r_outstanding <= r_outstanding - OUT_W'(1);
                    r_jobs_done   <= r_jobs_done + 16'd1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_offload_seq.sv
// Directed bench for hwpe_ctrl_offload_seq with the default parameters.
module tb_hwpe_ctrl_offload_seq;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [31:0]  base_addr_i;
    logic         job_valid_i;
    logic         job_ready_o;
    logic [127:0] job_data_i;
    logic         req_o;
    logic         gnt_i;
    logic [31:0]  add_o;
    logic         wen_o;
    logic [3:0]   be_o;
    logic [31:0]  data_o;
    logic [15:0]  id_o;
    logic [31:0]  r_data_i;
    logic         r_valid_i;
    logic         evt_done_i;
    logic         busy_o;
    logic [1:0]   outstanding_o;
    logic [15:0]  jobs_done_o;
    logic         err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [127:0] words;

    always #5 clk = ~clk;

    hwpe_ctrl_offload_seq dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .base_addr_i   (base_addr_i),
        .job_valid_i   (job_valid_i),
        .job_ready_o   (job_ready_o),
        .job_data_i    (job_data_i),
        .req_o         (req_o),
        .gnt_i         (gnt_i),
        .add_o         (add_o),
        .wen_o         (wen_o),
        .be_o          (be_o),
        .data_o        (data_o),
        .id_o          (id_o),
        .r_data_i      (r_data_i),
        .r_valid_i     (r_valid_i),
        .evt_done_i    (evt_done_i),
        .busy_o        (busy_o),
        .outstanding_o (outstanding_o),
        .jobs_done_o   (jobs_done_o),
        .err_o         (err_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_req"},  32'(req_o), 32'd1);
        check({tag, "_wen"},  32'(wen_o), 32'd0);
        check({tag, "_add"},  add_o, addr);
        check({tag, "_data"}, data_o, data);
    endtask

    task automatic check_done(input logic [1:0] outs, input logic [15:0] jobs);
        check("outstanding", 32'(outstanding_o), 32'(outs));
        check("jobs_done",   32'(jobs_done_o),   32'(jobs));
    endtask

    task automatic done_pulse();
        evt_done_i = 1'b1;
        cyc();
        evt_done_i = 1'b0;
    endtask

    // Runs one job on an idle bus and returns in the TRIGGER request cycle.
    task automatic do_job(input logic [31:0] base, input logic [127:0] w);
        base_addr_i = base;
        job_data_i  = w;
        job_valid_i = 1'b1;
        gnt_i       = 1'b1;
        check("job_ready_idle", 32'(job_ready_o), 32'd1);
        cyc();
        job_valid_i = 1'b0;
        check("acq_req",  32'(req_o), 32'd1);
        check("acq_wen",  32'(wen_o), 32'd1);
        check("acq_add",  add_o, base + 32'h04);
        check("acq_busy", 32'(busy_o), 32'd1);
        check("acq_rdy",  32'(job_ready_o), 32'd0);
        cyc();
        check("resp_req", 32'(req_o), 32'd0);
        r_valid_i = 1'b1;
        r_data_i  = 32'h0;
        cyc();
        r_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_write("wr", base + 32'h20 + 32'(4*k), w[k*32 +: 32]);
            cyc();
        end
        check_write("trig", base, 32'h0);
    endtask

    initial begin
        rst_i       = 1'b1;
        base_addr_i = '0;
        job_valid_i = 1'b0;
        job_data_i  = '0;
        gnt_i       = 1'b0;
        r_data_i    = '0;
        r_valid_i   = 1'b0;
        evt_done_i  = 1'b0;
        cyc();
        cyc();

        // Reset state
        check("rst_req",   32'(req_o), 32'd0);
        check("rst_wen",   32'(wen_o), 32'd1);
        check("rst_add",   add_o, 32'h0);
        check("rst_data",  data_o, 32'h0);
        check("rst_ready", 32'(job_ready_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_err",   32'(err_o), 32'd0);
        check("rst_be",    32'(be_o), 32'hF);
        check("rst_id",    32'(id_o), 32'd1);
        check_done(2'd0, 16'd0);
        rst_i = 1'b0;
        #1;
        check("ready_after_rst", 32'(job_ready_o), 32'd1);

        // Basic job: trigger 7 cycles after accept
        do_job(32'h1000, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
        check("pre_trig_outs", 32'(outstanding_o), 32'd0);
        cyc();
        check("post_trig_req", 32'(req_o), 32'd0);
        check("post_trig_rdy", 32'(job_ready_o), 32'd1);
        check("post_trig_busy", 32'(busy_o), 32'd1);
        check_done(2'd1, 16'd0);
        done_pulse();
        check_done(2'd0, 16'd1);
        check("idle_busy", 32'(busy_o), 32'd0);

        // Grant stall during job register 2
        words       = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
        base_addr_i = 32'h2000;
        job_data_i  = words;
        job_valid_i = 1'b1;
        gnt_i       = 1'b1;
        cyc();
        job_valid_i = 1'b0;
        check("st_acq_add", add_o, 32'h2004);
        cyc();
        r_valid_i = 1'b1;
        r_data_i  = 32'h0;
        cyc();
        r_valid_i = 1'b0;
        check_write("st_k0", 32'h2020, 32'hB000_0000);
        cyc();
        check_write("st_k1", 32'h2024, 32'hB000_0001);
        cyc();
        gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_write("st_hold", 32'h2028, 32'hB000_0002);
            cyc();
        end
        gnt_i = 1'b1;
        check_write("st_k2", 32'h2028, 32'hB000_0002);
        cyc();
        check_write("st_k3", 32'h202C, 32'hB000_0003);
        cyc();
        check_write("st_trig", 32'h2000, 32'h0);
        cyc();
        check_done(2'd1, 16'd1);
        done_pulse();
        check_done(2'd0, 16'd2);

        // Busy acquire: retry exactly 8 cycles after the busy response
        words       = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
        base_addr_i = 32'h3000;
        job_data_i  = words;
        job_valid_i = 1'b1;
        cyc();
        job_valid_i = 1'b0;
        check("bz_acq_add", add_o, 32'h3004);
        cyc();
        check("bz_resp_req", 32'(req_o), 32'd0);
        r_valid_i = 1'b1;
        r_data_i  = 32'hFFFF_FFFF;
        cyc();
        r_valid_i = 1'b0;
        for (int j = 1; j < 8; j++) begin
            check("bz_backoff_req", 32'(req_o), 32'd0);
            // A stray response during backoff must be ignored.
            r_valid_i = (j == 3);
            r_data_i  = 32'h0;
            cyc();
        end
        r_valid_i = 1'b0;
        check("bz_retry_req", 32'(req_o), 32'd1);
        check("bz_retry_wen", 32'(wen_o), 32'd1);
        check("bz_retry_add", add_o, 32'h3004);
        cyc();
        check("bz_resp2_req", 32'(req_o), 32'd0);
        cyc();
        r_valid_i = 1'b1;
        r_data_i  = 32'h1;
        cyc();
        r_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_write("bz_wr", 32'h3020 + 32'(4*k), words[k*32 +: 32]);
            cyc();
        end
        check_write("bz_trig", 32'h3000, 32'h0);
        cyc();
        check_done(2'd1, 16'd2);

        // Context full with two jobs in flight
        do_job(32'h4000, {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000});
        cyc();
        check_done(2'd2, 16'd2);
        job_valid_i = 1'b1;
        check("full_ready", 32'(job_ready_o), 32'd0);
        cyc();
        check("full_no_req", 32'(req_o), 32'd0);
        check("full_ready2", 32'(job_ready_o), 32'd0);
        check_done(2'd2, 16'd2);
        done_pulse();
        check_done(2'd1, 16'd3);
        check("freed_ready", 32'(job_ready_o), 32'd1);

        // Trigger grant coincides with done
        do_job(32'h5000, {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000});
        check("sim_pre_outs", 32'(outstanding_o), 32'd1);
        done_pulse();
        check_done(2'd1, 16'd4);
        done_pulse();
        check_done(2'd0, 16'd5);

        // Spurious done
        check("pre_spur_err", 32'(err_o), 32'd0);
        done_pulse();
        check("spur_err", 32'(err_o), 32'd1);
        check_done(2'd0, 16'd5);
        check("spur_busy", 32'(busy_o), 32'd0);

        // Reset in the middle of job register writes
        base_addr_i = 32'h6000;
        job_data_i  = {32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000};
        job_valid_i = 1'b1;
        gnt_i       = 1'b1;
        cyc();
        job_valid_i = 1'b0;
        cyc();
        r_valid_i = 1'b1;
        r_data_i  = 32'h0;
        cyc();
        r_valid_i = 1'b0;
        check_write("rs_k0", 32'h6020, 32'hF000_0000);
        cyc();
        check_write("rs_k1", 32'h6024, 32'hF000_0001);
        gnt_i = 1'b0;
        rst_i = 1'b1;
        cyc();
        check("rs_req",  32'(req_o), 32'd0);
        check("rs_add",  add_o, 32'h0);
        check("rs_wen",  32'(wen_o), 32'd1);
        check("rs_data", data_o, 32'h0);
        check("rs_err",  32'(err_o), 32'd0);
        check("rs_busy", 32'(busy_o), 32'd0);
        check("rs_rdy",  32'(job_ready_o), 32'd0);
        check_done(2'd0, 16'd0);
        rst_i = 1'b0;
        gnt_i = 1'b1;
        #1;
        check("rs_rdy_rel", 32'(job_ready_o), 32'd1);
        cyc();
        check("rs_idle_req",  32'(req_o), 32'd0);
        check("rs_idle_busy", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
